// File: rtl/game_judge.sv
// game_judge: tic-tac-toe referee. Grants alternating moves, detects wins
// and draws on the live board, holds the result for HOLD_CYCLES, then
// clears the board for a new game.
// Optional feature macro: GAME_JUDGE_SCORE_EN builds the per-side win
// counters; without it player_score and cpu_score are tied to 0.
module game_judge #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] board1,
  input  logic [1:0] board2,
  input  logic [1:0] board3,
  input  logic [1:0] board4,
  input  logic [1:0] board5,
  input  logic [1:0] board6,
  input  logic [1:0] board7,
  input  logic [1:0] board8,
  input  logic [1:0] board9,
  input  logic       player_done,
  input  logic       cpu_done,
  input  logic       start,
  output logic       clr,
  output logic       enable_player,
  output logic       enable_cpu,
  output logic       game_over,
  output logic [1:0] result,
  output logic [7:0] win_line,
  output logic [3:0] player_score,
  output logic [3:0] cpu_score
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] CODE_PLAYER = 2'b01;
  localparam logic [1:0] CODE_CPU    = 2'b10;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_CPU    = 2'b10;
  localparam logic [1:0] RES_DRAW   = 2'b11;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    PLAY   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
  logic [1:0]       result_next;
  logic [7:0]       win_line_next;
  logic             game_over_next;
  logic             clr_next;
  logic             enable_player_next;
  logic             enable_cpu_next;

  logic [7:0]       player_lines, cpu_lines;
  logic [7:0]       player_first, cpu_first;
  logic             board_full;
  logic             hold_done;

  function automatic logic line_hit(input logic [1:0] code,
                                    input logic [1:0] a,
                                    input logic [1:0] b,
                                    input logic [1:0] c);
    return (a == code) && (b == code) && (c == code);
  endfunction

  // Line detection: bit order rows, columns, main diagonal, anti-diagonal
  always_comb begin
    player_lines = {line_hit(CODE_PLAYER, board3, board5, board7),
                    line_hit(CODE_PLAYER, board1, board5, board9),
                    line_hit(CODE_PLAYER, board3, board6, board9),
                    line_hit(CODE_PLAYER, board2, board5, board8),
                    line_hit(CODE_PLAYER, board1, board4, board7),
                    line_hit(CODE_PLAYER, board7, board8, board9),
                    line_hit(CODE_PLAYER, board4, board5, board6),
                    line_hit(CODE_PLAYER, board1, board2, board3)};
    cpu_lines    = {line_hit(CODE_CPU, board3, board5, board7),
                    line_hit(CODE_CPU, board1, board5, board9),
                    line_hit(CODE_CPU, board3, board6, board9),
                    line_hit(CODE_CPU, board2, board5, board8),
                    line_hit(CODE_CPU, board1, board4, board7),
                    line_hit(CODE_CPU, board7, board8, board9),
                    line_hit(CODE_CPU, board4, board5, board6),
                    line_hit(CODE_CPU, board1, board2, board3)};
    // Isolate lowest set bit so only one winning line is reported
    player_first = player_lines & (~player_lines + 8'd1);
    cpu_first    = cpu_lines & (~cpu_lines + 8'd1);
    board_full   = (board1 != 2'b00) && (board2 != 2'b00) && (board3 != 2'b00) &&
                   (board4 != 2'b00) && (board5 != 2'b00) && (board6 != 2'b00) &&
                   (board7 != 2'b00) && (board8 != 2'b00) && (board9 != 2'b00);
    hold_done    = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CLEAR;
      hold_cnt      <= '0;
      result        <= RES_NONE;
      win_line      <= '0;
      game_over     <= 1'b0;
      clr           <= 1'b1;
      enable_player <= 1'b0;
      enable_cpu    <= 1'b0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_cnt_next;
      result        <= result_next;
      win_line      <= win_line_next;
      game_over     <= game_over_next;
      clr           <= clr_next;
      enable_player <= enable_player_next;
      enable_cpu    <= enable_cpu_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next     = state;
    hold_cnt_next  = hold_cnt;
    result_next    = result;
    win_line_next  = win_line;
    game_over_next = game_over;

    unique case (state)
      CLEAR: begin
        state_next     = PLAY;
        result_next    = RES_NONE;
        win_line_next  = '0;
        game_over_next = 1'b0;
      end
      PLAY: begin
        if (|player_lines) begin
          state_next     = RESULT;
          result_next    = RES_PLAYER;
          win_line_next  = player_first;
          game_over_next = 1'b1;
          hold_cnt_next  = '0;
        end else if (|cpu_lines) begin
          state_next     = RESULT;
          result_next    = RES_CPU;
          win_line_next  = cpu_first;
          game_over_next = 1'b1;
          hold_cnt_next  = '0;
        end else if (board_full) begin
          state_next     = RESULT;
          result_next    = RES_DRAW;
          win_line_next  = '0;
          game_over_next = 1'b1;
          hold_cnt_next  = '0;
        end
      end
      RESULT: begin
        if (hold_done || start) begin
          state_next     = CLEAR;
          result_next    = RES_NONE;
          win_line_next  = '0;
          game_over_next = 1'b0;
          hold_cnt_next  = '0;
        end else begin
          hold_cnt_next  = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next     = CLEAR;
        result_next    = RES_NONE;
        win_line_next  = '0;
        game_over_next = 1'b0;
        hold_cnt_next  = '0;
      end
    endcase

    clr_next           = (state_next == CLEAR);
    enable_player_next = (state_next == PLAY) && cpu_done;
    enable_cpu_next    = (state_next == PLAY) && player_done;
  end

`ifdef GAME_JUDGE_SCORE_EN
  // Saturating win counters, bumped on the edge that enters RESULT
  always_ff @(posedge clk) begin
    if (rst) begin
      player_score <= '0;
      cpu_score    <= '0;
    end else if (state == PLAY) begin
      if (|player_lines) begin
        if (player_score != 4'd15) player_score <= player_score + 4'd1;
      end else if (|cpu_lines) begin
        if (cpu_score != 4'd15) cpu_score <= cpu_score + 4'd1;
      end
    end
  end
`else
  assign player_score = 4'd0;
  assign cpu_score    = 4'd0;
`endif

endmodule

// File: tb/tb_game_judge.sv
// tb_game_judge: scoreboard bench for game_judge. A reference model pushes
// the expected registered outputs after every edge; a monitor pops and
// compares them shortly after the edge. Directed games first, then random.
module tb_game_judge;

  localparam int unsigned HOLD = 4;

  localparam logic [1:0] E = 2'd0;
  localparam logic [1:0] P = 2'd1;
  localparam logic [1:0] C = 2'd2;
  localparam logic [1:0] X = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] b [9];
  logic       player_done, cpu_done, start;
  logic       clr, enable_player, enable_cpu, game_over;
  logic [1:0] result;
  logic [7:0] win_line;
  logic [3:0] player_score, cpu_score;

  typedef struct packed {
    logic       clr;
    logic       ep;
    logic       ec;
    logic       go;
    logic [1:0] res;
    logic [7:0] line;
    logic [3:0] ps;
    logic [3:0] cs;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  game_judge #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst),
    .board1(b[0]), .board2(b[1]), .board3(b[2]),
    .board4(b[3]), .board5(b[4]), .board6(b[5]),
    .board7(b[6]), .board8(b[7]), .board9(b[8]),
    .player_done(player_done), .cpu_done(cpu_done), .start(start),
    .clr(clr), .enable_player(enable_player), .enable_cpu(enable_cpu),
    .game_over(game_over), .result(result), .win_line(win_line),
    .player_score(player_score), .cpu_score(cpu_score)
  );

  // ---------------- reference model ----------------
  // Phases: 0 = board being cleared, 1 = game in progress, 2 = showing result
  int         m_phase = 0;
  int         m_cnt   = 0;
  logic [1:0] m_res   = 2'd0;
  logic [7:0] m_line  = 8'd0;
  logic       m_go    = 1'b0;
  int         m_ps    = 0;
  int         m_cs    = 0;

  // Cells of each line, in win_line bit order
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8},
                       '{0,3,6}, '{1,4,7}, '{2,5,8},
                       '{0,4,8}, '{2,4,6}};

  function automatic int first_win(input logic [1:0] code);
    for (int l = 0; l < 8; l++) begin
      if (b[lines[l][0]] == code && b[lines[l][1]] == code && b[lines[l][2]] == code)
        return l;
    end
    return -1;
  endfunction

  task automatic model_step();
    obs_t e;
    int   pw, cw;
    bit   full;
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_res = 2'd0; m_line = 8'd0; m_go = 1'b0;
      m_ps = 0; m_cs = 0;
    end else begin
      case (m_phase)
        0: begin
          m_phase = 1; m_res = 2'd0; m_line = 8'd0; m_go = 1'b0;
        end
        1: begin
          pw = first_win(P);
          cw = first_win(C);
          full = 1'b1;
          for (int i = 0; i < 9; i++) if (b[i] == E) full = 1'b0;
          if (pw >= 0) begin
            m_phase = 2; m_cnt = 0; m_go = 1'b1; m_res = 2'd1;
            m_line = 8'd1 << pw;
            if (m_ps < 15) m_ps++;
          end else if (cw >= 0) begin
            m_phase = 2; m_cnt = 0; m_go = 1'b1; m_res = 2'd2;
            m_line = 8'd1 << cw;
            if (m_cs < 15) m_cs++;
          end else if (full) begin
            m_phase = 2; m_cnt = 0; m_go = 1'b1; m_res = 2'd3; m_line = 8'd0;
          end
        end
        default: begin
          if (m_cnt == int'(HOLD) - 1 || start) begin
            m_phase = 0; m_res = 2'd0; m_line = 8'd0; m_go = 1'b0;
          end else begin
            m_cnt++;
          end
        end
      endcase
    end
    e.clr  = (m_phase == 0);
    e.ep   = (m_phase == 1) && cpu_done;
    e.ec   = (m_phase == 1) && player_done;
    e.go   = m_go;
    e.res  = m_res;
    e.line = m_line;
`ifdef GAME_JUDGE_SCORE_EN
    e.ps   = 4'(m_ps);
    e.cs   = 4'(m_cs);
`else
    e.ps   = 4'd0;
    e.cs   = 4'd0;
`endif
    exp_q.push_back(e);
  endtask

  // Model runs on every edge with the inputs the DUT sampled
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare DUT outputs shortly after each edge
  initial forever begin
    obs_t e, a;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{clr: clr, ep: enable_player, ec: enable_cpu, go: game_over,
            res: result, line: win_line, ps: player_score, cs: cpu_score};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got clr=%b ep=%b ec=%b go=%b res=%b line=%b ps=%0d cs=%0d want clr=%b ep=%b ec=%b go=%b res=%b line=%b ps=%0d cs=%0d",
                 $time, a.clr, a.ep, a.ec, a.go, a.res, a.line, a.ps, a.cs,
                 e.clr, e.ep, e.ec, e.go, e.res, e.line, e.ps, e.cs);
      end
    end
  end

  // Direct check of selected outputs at the current time
  task automatic check_sig(input string what, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b want=%b", what, $time, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic put9(input logic [1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9);
    b[0] = c1; b[1] = c2; b[2] = c3;
    b[3] = c4; b[4] = c5; b[5] = c6;
    b[6] = c7; b[7] = c8; b[8] = c9;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a board for one cycle, then empty it and let the game cycle round
  task automatic play_board(input logic [1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9);
    put9(c1, c2, c3, c4, c5, c6, c7, c8, c9);
    cycles(1);
    check_sig("result_entry_go", 8'(game_over), 8'd1);
    put9(E, E, E, E, E, E, E, E, E);
    cycles(HOLD - 1);
    check_sig("hold_last_go", 8'(game_over), 8'd1);
    cycles(1);
    check_sig("expired_go", 8'(game_over), 8'd0);
    check_sig("expired_clr", 8'(clr), 8'd1);
    check_sig("expired_res", 8'(result), 8'd0);
    check_sig("expired_line", win_line, 8'd0);
    cycles(1);
    check_sig("after_clear_clr", 8'(clr), 8'd0);
    cycles(2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; player_done = 1'b0; cpu_done = 1'b0;
    put9(E, E, E, E, E, E, E, E, E);
    cycles(3);
    check_sig("reset_clr", 8'(clr), 8'd1);
    check_sig("reset_go", 8'(game_over), 8'd0);
    check_sig("reset_res", 8'(result), 8'd0);
    check_sig("reset_line", win_line, 8'd0);
    rst = 1'b0;
    cycles(3);

    // Move grants follow the done flags by one cycle
    player_done = 1'b1; cycles(1);
    player_done = 1'b0; cpu_done = 1'b1; cycles(1);
    cpu_done = 1'b0; cycles(1);

    play_board(P, P, P, E, E, E, E, E, E);          // row 1 player
    play_board(E, E, C, E, C, E, C, E, E);          // anti-diagonal cpu
    play_board(P, C, P, P, C, C, C, P, P);          // draw
    play_board(P, E, E, P, P, P, P, E, E);          // row 2 + col 1: lowest only
    play_board(C, C, C, E, E, E, P, P, P);          // both win: player first
    play_board(X, X, X, P, C, P, C, P, C);          // 11 line is not a win: draw

    // Early restart on the second RESULT cycle
    put9(P, E, E, E, P, E, E, E, P);
    cycles(1);
    put9(E, E, E, E, E, E, E, E, E);
    cycles(1);
    start = 1'b1; cycles(1);
    start = 1'b0; cycles(4);

    // Start together with expiry on the last hold cycle
    put9(E, C, E, E, C, E, E, C, E);
    cycles(1);
    put9(E, E, E, E, E, E, E, E, E);
    cycles(HOLD - 1);
    start = 1'b1; cycles(1);
    start = 1'b0; cycles(4);

    // Reset in the middle of RESULT
    put9(E, E, P, E, E, P, E, E, P);
    cycles(2);
    rst = 1'b1; cycles(1);
    rst = 1'b0;
    put9(E, E, E, E, E, E, E, E, E);
    cycles(4);

    // Repeated player wins drive the score to saturation
    start = 1'b1;
    put9(P, P, P, E, E, E, E, E, E);
    cycles(60);
    start = 1'b0;
    put9(E, E, E, E, E, E, E, E, E);
    cycles(HOLD + 3);

    // Random play
    for (int k = 0; k < 2500; k++) begin
      b[$urandom_range(0, 8)] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) put9(E, E, E, E, E, E, E, E, E);
      start       = ($urandom_range(0, 3) == 0);
      player_done = 1'($urandom_range(0, 1));
      cpu_done    = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 299) == 0);
      cycles(1);
    end
    rst = 1'b0; start = 1'b0;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_judge.md
GAME_JUDGE -- requirements
Module: game_judge

Interface
REQ-001 Parameter: HOLD_CYCLES, default 16, number of cycles the result is held before an automatic clear.
REQ-002 Port: clk  in  1  system clock; every register updates on its rising edge.
REQ-003 Port: rst  in  1  synchronous active-high reset.
REQ-004 Ports: board1..board9  in  2 each  cell state, row-major (1 = top-left); 00 empty, 01 player, 10 cpu, 11 invalid.
REQ-005 Port: player_done  in  1  board stage flag; 1 after a player move.
REQ-006 Port: cpu_done  in  1  board stage flag; 1 after a cpu move.
REQ-007 Port: start  in  1  level; in RESULT, a 1 requests an early new game.
REQ-008 Port: clr  out  1  board-clear command to the board stage.
REQ-009 Port: enable_player  out  1  grants a player move.
REQ-010 Port: enable_cpu  out  1  grants a cpu move.
REQ-011 Port: game_over  out  1  high while a result is held.
REQ-012 Port: result  out  2  00 none, 01 player win, 10 cpu win, 11 draw.
REQ-013 Port: win_line  out  8  one-hot winning line; order is rows 1-3, then columns 1-3, then diagonal 1-5-9, then diagonal 3-5-7.
REQ-014 Ports: player_score, cpu_score  out  4 each  games won by each side.

Function
REQ-015 The FSM SHALL have exactly three states, CLEAR, PLAY and RESULT, and all outputs SHALL be registered.
REQ-016 CLEAR SHALL assert clr for exactly one cycle, hold both enables at 0, and go to PLAY on the next edge.
REQ-017 In PLAY, enable_player SHALL be cpu_done delayed one cycle, and enable_cpu SHALL be player_done delayed one cycle; in other states both SHALL be 0.
REQ-018 A line SHALL count as a win for a side only when all three of its cells equal that side's code (01 or 10); cells coded 11 SHALL never form a win.
REQ-019 The win check SHALL run in PLAY on every cycle against the current board inputs.
REQ-020 If both sides have winning lines in the same cycle, the player win SHALL take priority.
REQ-021 If no win exists and all nine cells are non-zero, the game SHALL be a draw.
REQ-022 Latency: on the first edge where a win or draw holds, the FSM SHALL enter RESULT and, on that same edge, set game_over=1, result, win_line and the score update; they are visible one cycle after the board change.
REQ-023 When the player wins more than one line at once, win_line SHALL have only the lowest-index winning bit set.
REQ-024 For a draw, win_line SHALL be 0.
REQ-025 On entry to RESULT, the winner's score SHALL increment by 1 and saturate at 15; a draw SHALL change neither score.
REQ-026 RESULT SHALL run a hold counter from 0; when the counter reaches HOLD_CYCLES-1, or when start=1, the FSM SHALL go to CLEAR on the next edge.
REQ-027 If start=1 and counter expiry occur in the same cycle, only a single transition to CLEAR SHALL occur.
REQ-028 On the edge that enters CLEAR, game_over SHALL drop to 0, result and win_line SHALL go to 0, and the scores SHALL be retained.
REQ-029 In PLAY and CLEAR, start SHALL be ignored.
REQ-030 Board changes while in RESULT or CLEAR SHALL not alter result, win_line or the scores.

Reset
REQ-031 While rst=1 on an edge, the FSM SHALL go to CLEAR, and the hold counter, result, win_line, game_over, both enables and both scores SHALL go to 0.
REQ-032 During reset, clr SHALL be driven to 1, so that the board is cleared while reset is held.
REQ-033 Reset SHALL take priority over every other event, including a reset asserted in the middle of RESULT.
REQ-034 After rst falls, there SHALL be one CLEAR cycle with clr=1, followed by PLAY.

Configuration
REQ-035 Macro GAME_JUDGE_SCORE_EN:
- Defined: the score counters SHALL be built as described in REQ-025.
- Undefined: no score registers SHALL exist, and player_score and cpu_score SHALL be tied to 0.
- Undefined: all other behaviour SHALL be unchanged.

Verification
REQ-036 Scenario: rst=1 for 3 cycles, then 0 -> clr=1 throughout reset, then 1 CLEAR cycle with clr=1, then PLAY with clr=0 and result=00.
REQ-037 Scenario: in PLAY, board1=board2=board3=01 -> next cycle game_over=1, result=01, win_line=8'b0000_0001, player_score=1.
REQ-038 Scenario: in PLAY, board3=board5=board7=10 -> result=10, win_line=8'b1000_0000, cpu_score increments.
REQ-039 Scenario: full board with no line (01,10,01 / 01,10,10 / 10,01,01) -> result=11, win_line=0, scores unchanged.
REQ-040 Scenario: HOLD_CYCLES=4, player win -> game_over stays 1 for exactly 4 cycles, then 1 CLEAR cycle with clr=1, then PLAY; start=1 on the 2nd RESULT cycle -> CLEAR on the next edge.
REQ-041 Scenario: 16 consecutive player wins -> player_score saturates at 15; with GAME_JUDGE_SCORE_EN undefined, both scores stay 0.
